// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM states, digit
// moduli and the helper that maps a digit position to its modulus.
package timer_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 8;
    localparam int MOD_DEC    = 10;
    localparam int MOD_SEX    = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Digit order is least significant first: sec_3, sec_2, sec_1, sec_0,
    // min_1, min_0, hr_1, hr_0. The tens-of-seconds and tens-of-minutes
    // positions are base 6; every other position is base 10.
    function automatic int digit_mod(input int idx);
        return ((idx == 3) || (idx == 5)) ? MOD_SEX : MOD_DEC;
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// One BCD down-counting digit with parallel load and a combinational
// borrow chain, so a whole cascade settles within a single clock.
module bcd_down_counter
    import timer_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic               i_clk,
    input  logic               i_sclr,
    input  logic               i_load,
    input  logic [DIGIT_W-1:0] i_din,
    input  logic               i_bin,
    output logic [DIGIT_W-1:0] o_cnt,
    output logic               o_bout
);

    localparam logic [DIGIT_W-1:0] TOP = DIGIT_W'(MOD - 1);

    logic [DIGIT_W-1:0] cnt_q;
    logic [DIGIT_W-1:0] cnt_d;

    // Load has precedence; a borrow from zero wraps to the top of the digit.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_din;
        end else if (i_bin) begin
            cnt_d = (cnt_q == '0) ? TOP : cnt_q - DIGIT_W'(1);
        end
    end

    // Digit register with synchronous clear.
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_bout = i_bin & (cnt_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable HH:MM:SS.cc countdown timer: prescaler to a 100 Hz tick, a
// cascade of eight BCD down-counters, preset validation and a run FSM.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MODULUS = 500000,
    parameter int TICK_W  = 19
) (
    input  logic         i_clk,
    input  logic         i_sclr,
    input  logic         i_load,
    input  logic         i_start,
    input  logic         i_pause,
    input  logic [3:0]   i_pre_sec_3,
    input  logic [3:0]   i_pre_sec_2,
    input  logic [3:0]   i_pre_sec_1,
    input  logic [3:0]   i_pre_sec_0,
    input  logic [3:0]   i_pre_min_1,
    input  logic [3:0]   i_pre_min_0,
    input  logic [3:0]   i_pre_hr_1,
    input  logic [3:0]   i_pre_hr_0,
    output logic [3:0]   o_sec_3,
    output logic [3:0]   o_sec_2,
    output logic [3:0]   o_sec_1,
    output logic [3:0]   o_sec_0,
    output logic [3:0]   o_min_1,
    output logic [3:0]   o_min_0,
    output logic [3:0]   o_hr_1,
    output logic [3:0]   o_hr_0,
    output logic         o_running,
    output logic         o_done,
    output logic         o_expired,
    output logic         o_load_err
);

    localparam logic [TICK_W-1:0] PRESC_MAX = TICK_W'(MODULUS - 1);

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   presc_q, presc_d;
    logic                done_q, done_d;
    logic                load_err_q, load_err_d;

    logic [DIGIT_W-1:0]  pre_dig [NUM_DIGITS];
    logic [DIGIT_W-1:0]  cnt_dig [NUM_DIGITS];
    logic [NUM_DIGITS:0] borrow;
    logic                dig_load;
    logic                tick;
    logic                preset_valid;
    logic                digits_zero;
    logic                last_count;
    logic                unused_final_borrow;

    assign pre_dig[0] = i_pre_sec_3;
    assign pre_dig[1] = i_pre_sec_2;
    assign pre_dig[2] = i_pre_sec_1;
    assign pre_dig[3] = i_pre_sec_0;
    assign pre_dig[4] = i_pre_min_1;
    assign pre_dig[5] = i_pre_min_0;
    assign pre_dig[6] = i_pre_hr_1;
    assign pre_dig[7] = i_pre_hr_0;

    assign borrow[0] = tick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_down_counter #(
                .MOD (digit_mod(gi))
            ) u_digit (
                .i_clk  (i_clk),
                .i_sclr (i_sclr),
                .i_load (dig_load),
                .i_din  (pre_dig[gi]),
                .i_bin  (borrow[gi]),
                .o_cnt  (cnt_dig[gi]),
                .o_bout (borrow[gi+1])
            );
        end
    endgenerate

    // The timer never ticks from all-zero, so a borrow out of hr_0 cannot occur.
    assign unused_final_borrow = borrow[NUM_DIGITS];

    // Preset check, zero detect, and detect of the last remaining count (.01).
    always_comb begin
        preset_valid = 1'b1;
        digits_zero  = 1'b1;
        last_count   = (cnt_dig[0] == DIGIT_W'(1));
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pre_dig[i] > DIGIT_W'(digit_mod(i) - 1)) begin
                preset_valid = 1'b0;
            end
            if (cnt_dig[i] != '0) begin
                digits_zero = 1'b0;
            end
            if ((i != 0) && (cnt_dig[i] != '0)) begin
                last_count = 1'b0;
            end
        end
    end

    // Next-state, prescaler and pulse logic; priority load > pause > start.
    // A load during RUN is treated as absent so the remaining controls still apply.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        dig_load   = 1'b0;
        tick       = 1'b0;
        if (i_load && (state_q != ST_RUN)) begin
            if (preset_valid) begin
                dig_load = 1'b1;
                presc_d  = '0;
                state_d  = ST_IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (i_pause && (state_q == ST_RUN)) begin
            state_d = ST_PAUSE;
        end else if (i_start && (state_q == ST_IDLE)) begin
            if (digits_zero) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
                presc_d = '0;
            end
        end else if (i_start && (state_q == ST_PAUSE)) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (presc_q == PRESC_MAX) begin
                tick    = 1'b1;
                presc_d = '0;
                if (last_count) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + TICK_W'(1);
            end
        end
    end

    // State, prescaler and pulse registers.
    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign o_sec_3    = cnt_dig[0];
    assign o_sec_2    = cnt_dig[1];
    assign o_sec_1    = cnt_dig[2];
    assign o_sec_0    = cnt_dig[3];
    assign o_min_1    = cnt_dig[4];
    assign o_min_0    = cnt_dig[5];
    assign o_hr_1     = cnt_dig[6];
    assign o_hr_0     = cnt_dig[7];
    assign o_running  = (state_q == ST_RUN);
    assign o_expired  = (state_q == ST_DONE);
    assign o_done     = done_q;
    assign o_load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with a small prescaler. The
// reference model tracks remaining time as an integer number of
// centiseconds and derives the displayed digits by division.
module tb_countdown_timer;

    localparam int MODULUS = 4;
    localparam int TICK_W  = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk   = 1'b0;
    logic       sclr  = 1'b1;
    logic       load  = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] pre [8];   // 0 = sec_3 (hundredths) ... 7 = hr_0 (tens of hours)
    logic [3:0] o_sec_3, o_sec_2, o_sec_1, o_sec_0, o_min_1, o_min_0, o_hr_1, o_hr_0;
    logic       o_running, o_done, o_expired, o_load_err;

    int   n_pass  = 0;
    int   n_total = 0;

    int   m_total = 0;
    int   m_phase = 0;
    int   m_st    = M_IDLE;
    logic m_done  = 1'b0;
    logic m_err   = 1'b0;

    countdown_timer #(
        .MODULUS (MODULUS),
        .TICK_W  (TICK_W)
    ) dut (
        .i_clk       (clk),
        .i_sclr      (sclr),
        .i_load      (load),
        .i_start     (start),
        .i_pause     (pause),
        .i_pre_sec_3 (pre[0]),
        .i_pre_sec_2 (pre[1]),
        .i_pre_sec_1 (pre[2]),
        .i_pre_sec_0 (pre[3]),
        .i_pre_min_1 (pre[4]),
        .i_pre_min_0 (pre[5]),
        .i_pre_hr_1  (pre[6]),
        .i_pre_hr_0  (pre[7]),
        .o_sec_3     (o_sec_3),
        .o_sec_2     (o_sec_2),
        .o_sec_1     (o_sec_1),
        .o_sec_0     (o_sec_0),
        .o_min_1     (o_min_1),
        .o_min_0     (o_min_0),
        .o_hr_1      (o_hr_1),
        .o_hr_0      (o_hr_0),
        .o_running   (o_running),
        .o_done      (o_done),
        .o_expired   (o_expired),
        .o_load_err  (o_load_err)
    );

    always #5 clk = ~clk;

    function automatic logic preset_ok();
        for (int i = 0; i < 8; i++) begin
            if (pre[i] > 4'd9) return 1'b0;
        end
        return (pre[3] <= 4'd5) && (pre[5] <= 4'd5);
    endfunction

    function automatic int preset_cs();
        int h, mn, s, c;
        h  = int'(pre[7]) * 10 + int'(pre[6]);
        mn = int'(pre[5]) * 10 + int'(pre[4]);
        s  = int'(pre[3]) * 10 + int'(pre[2]);
        c  = int'(pre[1]) * 10 + int'(pre[0]);
        return h * 360000 + mn * 6000 + s * 100 + c;
    endfunction

    function automatic logic [31:0] model_digits();
        int cs, s, mn, h;
        cs = m_total;
        s  = (cs / 100) % 60;
        mn = (cs / 6000) % 60;
        h  = cs / 360000;
        return {4'(h / 10), 4'(h % 10), 4'(mn / 10), 4'(mn % 10),
                4'(s / 10), 4'(s % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
    endfunction

    function automatic logic [31:0] dut_digits();
        return {o_hr_0, o_hr_1, o_min_0, o_min_1, o_sec_0, o_sec_1, o_sec_2, o_sec_3};
    endfunction

    function automatic logic [35:0] model_vec();
        return {model_digits(), (m_st == M_RUN), m_done, (m_st == M_DONE), m_err};
    endfunction

    function automatic logic [35:0] dut_vec();
        return {dut_digits(), o_running, o_done, o_expired, o_load_err};
    endfunction

    // Behavioural reference: one call per clock edge with the sampled inputs.
    task automatic model_step();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (sclr) begin
            m_total = 0; m_phase = 0; m_st = M_IDLE;
        end else if (load && m_st != M_RUN) begin
            if (preset_ok()) begin
                m_total = preset_cs(); m_phase = 0; m_st = M_IDLE;
            end else begin
                m_err = 1'b1;
            end
        end else if (pause && m_st == M_RUN) begin
            m_st = M_PAUSE;
        end else if (start && m_st == M_IDLE) begin
            if (m_total == 0) begin
                m_st = M_DONE; m_done = 1'b1;
            end else begin
                m_st = M_RUN; m_phase = 0;
            end
        end else if (start && m_st == M_PAUSE) begin
            m_st = M_RUN;
        end else if (m_st == M_RUN) begin
            m_phase++;
            if (m_phase == MODULUS) begin
                m_phase = 0;
                m_total--;
                if (m_total == 0) begin
                    m_st = M_DONE; m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input logic ld, input logic st, input logic ps, input logic sc);
        load = ld; start = st; pause = ps; sclr = sc;
        @(posedge clk);
        model_step();
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; sclr = 1'b0;
    endtask

    task automatic set_pre(input int h0, input int h1, input int m0, input int m1,
                           input int s0, input int s1, input int s2, input int s3);
        pre[7] = 4'(h0); pre[6] = 4'(h1); pre[5] = 4'(m0); pre[4] = 4'(m1);
        pre[3] = 4'(s0); pre[2] = 4'(s1); pre[1] = 4'(s2); pre[0] = 4'(s3);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (dut_vec() !== 36'h0) $display("FAIL reset: got %h expected %h", dut_vec(), 36'h0);
        else n_pass++;
        $display("reset: outputs %h", dut_vec());
    endtask

    task automatic test_countdown();
        int done_cnt;
        done_cnt = 0;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        set_pre(0, 0, 0, 0, 0, 0, 0, 3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (o_done === 1'b1) begin
                done_cnt++;
                n_total++;
                if (o_running !== 1'b0 || dut_digits() !== 32'h0)
                    $display("FAIL countdown_done_cycle: got run=%b dig=%h expected run=0 dig=0", o_running, dut_digits());
                else n_pass++;
            end
            n_total++;
            if (dut_vec() !== model_vec())
                $display("FAIL countdown cyc%0d: got %h expected %h", i, dut_vec(), model_vec());
            else n_pass++;
        end
        n_total++;
        if (done_cnt != 1 || o_expired !== 1'b1)
            $display("FAIL countdown_expiry: got done_pulses=%0d expired=%b expected 1 and 1", done_cnt, o_expired);
        else n_pass++;
        $display("countdown: done pulses %0d expired %b", done_cnt, o_expired);
    endtask

    task automatic test_borrow();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        set_pre(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= MODULUS; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_total++;
            if (dut_vec() !== model_vec())
                $display("FAIL borrow cyc%0d: got %h expected %h", i, dut_vec(), model_vec());
            else n_pass++;
        end
        n_total++;
        if (dut_digits() !== 32'h0000_5999)
            $display("FAIL borrow_chain: got %h expected %h", dut_digits(), 32'h0000_5999);
        else n_pass++;
        $display("borrow: digits %h", dut_digits());
    endtask

    task automatic test_pause();
        int first_tick;
        first_tick = -1;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        set_pre(0, 0, 0, 0, 0, 0, 5, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_total++;
            if (dut_vec() !== model_vec() || dut_digits() !== 32'h0000_0049 || o_running !== 1'b0)
                $display("FAIL pause_hold cyc%0d: got %h expected %h", i, dut_vec(), model_vec());
            else n_pass++;
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            if (first_tick < 0 && dut_digits() !== 32'h0000_0049) first_tick = k;
        end
        n_total++;
        if (first_tick != 2)
            $display("FAIL pause_resume: got first tick after %0d cycles expected 2", first_tick);
        else n_pass++;
        n_total++;
        if (dut_vec() !== model_vec())
            $display("FAIL pause_after: got %h expected %h", dut_vec(), model_vec());
        else n_pass++;
        $display("pause: first tick %0d cycles after resume", first_tick);
    endtask

    task automatic test_load_err();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        set_pre(0, 0, 0, 0, 0, 0, 0, 5);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 2; t++) begin
            if (t == 0) set_pre(0, 0, 0, 0, 7, 0, 0, 1);
            else        set_pre(0, 10, 0, 0, 0, 0, 0, 1);
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            n_total++;
            if (dut_vec() !== {32'h0000_0005, 4'b0001} || dut_vec() !== model_vec())
                $display("FAIL load_err%0d: got %h expected %h", t, dut_vec(), {32'h0000_0005, 4'b0001});
            else n_pass++;
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_total++;
            if (dut_vec() !== {32'h0000_0005, 4'b0000})
                $display("FAIL load_err_clear%0d: got %h expected %h", t, dut_vec(), {32'h0000_0005, 4'b0000});
            else n_pass++;
            $display("load_err%0d: outputs %h", t, dut_vec());
        end
    endtask

    task automatic test_zero_start();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        set_pre(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (dut_vec() !== 36'h0_0000_0006) $display("FAIL zero_start: got %h expected %h", dut_vec(), 36'h0_0000_0006);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (dut_vec() !== 36'h0_0000_0002) $display("FAIL zero_done_once: got %h expected %h", dut_vec(), 36'h0_0000_0002);
        else n_pass++;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (dut_vec() !== 36'h0_0000_0002) $display("FAIL done_ignores_start: got %h expected %h", dut_vec(), 36'h0_0000_0002);
        else n_pass++;
        set_pre(0, 0, 0, 0, 0, 0, 0, 2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (dut_vec() !== 36'h0_0000_0020) $display("FAIL done_reload: got %h expected %h", dut_vec(), 36'h0_0000_0020);
        else n_pass++;
        $display("zero_start: outputs %h", dut_vec());
    endtask

    task automatic test_sclr();
        set_pre(1, 2, 3, 4, 5, 6, 7, 8);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (dut_vec() !== model_vec()) $display("FAIL sclr_prerun: got %h expected %h", dut_vec(), model_vec());
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        n_total++;
        if (dut_vec() !== 36'h0) $display("FAIL sclr_midrun: got %h expected %h", dut_vec(), 36'h0);
        else n_pass++;
        set_pre(0, 0, 0, 0, 0, 0, 0, 9);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (dut_vec() !== 36'h0_0000_0090) $display("FAIL load_beats_start: got %h expected %h", dut_vec(), 36'h0_0000_0090);
        else n_pass++;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_total++;
        if (dut_vec() !== 36'h0_0000_0090) $display("FAIL load_beats_start_hold: got %h expected %h", dut_vec(), 36'h0_0000_0090);
        else n_pass++;
        $display("sclr: outputs %h", dut_vec());
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            logic ld, st, ps, sc;
            sc = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 4) == 0);
            ps = ($urandom_range(0, 11) == 0);
            if (ld) begin
                set_pre(0, 0, 0, 0, 0, 0, 0, 0);
                pre[0] = 4'($urandom_range(0, 9));
                pre[1] = 4'($urandom_range(0, 2));
                if ($urandom_range(0, 7) == 0) pre[3] = 4'($urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0) pre[6] = 4'($urandom_range(8, 11));
                if ($urandom_range(0, 9) == 0) pre[0] = 4'($urandom_range(10, 15));
            end
            cycle(ld, st, ps, sc);
            n_total++;
            if (dut_vec() !== model_vec()) begin
                errs++;
                $display("FAIL random cyc%0d: got %h expected %h", i, dut_vec(), model_vec());
            end else n_pass++;
        end
        $display("random: 600 cycles, %0d differences", errs);
    endtask

    initial begin
        set_pre(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_countdown();
        test_borrow();
        test_pause();
        test_load_err();
        test_zero_start();
        test_sclr();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
